// File: rtl/tx_framer_pkg.sv
// Shared PCIe PHY definitions for the TX framer: K-code symbols, the framer
// state enum and small width/index helpers.
package tx_framer_pkg;

    // K-code symbols that delimit and pad a frame.
    localparam logic [7:0] K_STP = 8'hFB;
    localparam logic [7:0] K_END = 8'hFD;
    localparam logic [7:0] K_PAD = 8'hF7;

    typedef enum logic [2:0] {
        IDLE,
        STP,
        DATA,
        END,
        PAD
    } state_e;

    // Width of a counter that must hold 0..n-1. Never zero, so a 1-lane
    // build still gets a legal 1-bit vector.
    function automatic int f_cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Index of the last valid byte in a word. Non-EOP words are always full.
    // last_bytes of 0 means 4 bytes, which wraps naturally to index 3.
    function automatic logic [1:0] f_last_idx(input logic eop, input logic [1:0] last_bytes);
        if (!eop) begin
            return 2'd3;
        end
        return last_bytes - 2'd1;
    endfunction

endpackage

// File: rtl/tx_framer_if.sv
// Word-in / symbol-out handshake bundle of the TX framer.
// The slave modport is the framer's view; the master modport is the view of
// the logic surrounding it (TLP source and lane striper).
interface tx_framer_if #(
    parameter int DATA_WIDTH = 8
);

    logic [31:0]           tlp_data_i;
    logic                  tlp_valid_i;
    logic                  tlp_ready_o;
    logic                  tlp_sop_i;
    logic                  tlp_eop_i;
    logic [1:0]            tlp_last_bytes_i;
    logic [DATA_WIDTH-1:0] framed_data_o;
    logic                  framed_is_k_o;
    logic                  framed_valid_o;
    logic                  framed_ready_i;

    modport master (
        output tlp_data_i,
        output tlp_valid_i,
        output tlp_sop_i,
        output tlp_eop_i,
        output tlp_last_bytes_i,
        output framed_ready_i,
        input  tlp_ready_o,
        input  framed_data_o,
        input  framed_is_k_o,
        input  framed_valid_o
    );

    modport slave (
        input  tlp_data_i,
        input  tlp_valid_i,
        input  tlp_sop_i,
        input  tlp_eop_i,
        input  tlp_last_bytes_i,
        input  framed_ready_i,
        output tlp_ready_o,
        output framed_data_o,
        output framed_is_k_o,
        output framed_valid_o
    );

endinterface

// File: rtl/unary_to_binary.sv
// Converts a lane-enable thermometer code into a binary "count minus one".
// An all-zero input reads as one lane (output 0), so a caller adding 1 back
// never sees a zero lane count.
module unary_to_binary
    import tx_framer_pkg::*;
#(
    parameter int N = 4,
    localparam int OUT_W = f_cnt_w(N)
) (
    input  logic             i_unary [N],
    output logic [OUT_W-1:0] o_bin
);

    localparam int COUNT_W = $clog2(N + 1);

    logic [N-1:0]       w_bits;
    logic [COUNT_W-1:0] w_count;

    for (genvar gi = 0; gi < N; gi++) begin : g_pack
        assign w_bits[gi] = i_unary[gi];
    end

    assign w_count = COUNT_W'($countones(w_bits));

    // Saturate the empty code to one lane, otherwise report count - 1.
    always_comb begin
        o_bin = '0;
        if (w_count != '0) begin
            o_bin = OUT_W'(w_count - COUNT_W'(1));
        end
    end

endmodule

// File: rtl/tx_framer.sv
// TX framer: wraps each TLP in STP ... END K-codes, serializes its 32-bit
// words byte by byte, and appends PAD symbols so every frame length is a
// multiple of the lane count captured at the start of the frame.
module tx_framer
    import tx_framer_pkg::*;
#(
    parameter int NUM_LANES  = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    tx_framer_if.slave tlp_bus,
    input  logic       num_lanes_enabled_i [NUM_LANES],
    output logic       frame_err_o
);

    localparam int CNT_W  = f_cnt_w(NUM_LANES);
    localparam int LANE_W = $clog2(NUM_LANES + 1);

    state_e                r_state;
    state_e                w_state_next;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_cnt_next;
    logic [CNT_W-1:0]      w_cnt_wrap;
    logic [CNT_W-1:0]      w_u2b;
    logic [LANE_W-1:0]     r_lanes;
    logic [LANE_W-1:0]     w_lanes_next;
    logic [LANE_W-1:0]     w_lanes_now;
    logic [LANE_W-1:0]     w_cnt_plus;
    logic [1:0]            r_byte_idx;
    logic [1:0]            w_byte_idx_next;
    logic [1:0]            w_last_idx;
    logic                  r_first_word;
    logic                  w_first_word_next;
    logic                  r_frame_err;
    logic                  w_frame_err_next;
    logic                  w_valid;
    logic                  w_is_k;
    logic                  w_ready;
    logic                  w_xfer;
    logic [7:0]            w_byte;
    logic [DATA_WIDTH-1:0] w_data;

    unary_to_binary #(
        .N (NUM_LANES)
    ) u_lane_count (
        .i_unary (num_lanes_enabled_i),
        .o_bin   (w_u2b)
    );

    // Live lane count; only captured when a frame starts.
    assign w_lanes_now = LANE_W'(w_u2b) + LANE_W'(1);

    // Symbol position within the current lane-wide beat after one more transfer.
    assign w_cnt_plus = LANE_W'(r_cnt) + LANE_W'(1);
    assign w_cnt_wrap = (w_cnt_plus == r_lanes) ? '0 : w_cnt_plus[CNT_W-1:0];

    assign w_xfer     = w_valid & tlp_bus.framed_ready_i;
    assign w_last_idx = f_last_idx(tlp_bus.tlp_eop_i, tlp_bus.tlp_last_bytes_i);

    // Select the byte of the held input word that is currently being sent.
    always_comb begin
        case (r_byte_idx)
            2'd0:    w_byte = tlp_bus.tlp_data_i[7:0];
            2'd1:    w_byte = tlp_bus.tlp_data_i[15:8];
            2'd2:    w_byte = tlp_bus.tlp_data_i[23:16];
            default: w_byte = tlp_bus.tlp_data_i[31:24];
        endcase
    end

    // Next-state, counters and symbol outputs for the framing FSM.
    always_comb begin
        w_state_next      = r_state;
        w_cnt_next        = r_cnt;
        w_lanes_next      = r_lanes;
        w_byte_idx_next   = r_byte_idx;
        w_first_word_next = r_first_word;
        w_frame_err_next  = 1'b0;
        w_valid           = 1'b0;
        w_is_k            = 1'b0;
        w_ready           = 1'b0;
        w_data            = '0;

        case (r_state)
            IDLE: begin
                w_cnt_next      = '0;
                w_byte_idx_next = 2'd0;
                if (tlp_bus.tlp_valid_i) begin
                    if (tlp_bus.tlp_sop_i) begin
                        // Sop word stays at the input until DATA consumes it.
                        w_state_next      = STP;
                        w_lanes_next      = w_lanes_now;
                        w_first_word_next = 1'b1;
                    end else begin
                        // Stray word outside a packet: swallow it and flag it.
                        w_ready          = 1'b1;
                        w_frame_err_next = 1'b1;
                    end
                end
            end

            STP: begin
                w_valid     = 1'b1;
                w_is_k      = 1'b1;
                w_data[7:0] = K_STP;
                if (w_xfer) begin
                    w_cnt_next   = w_cnt_wrap;
                    w_state_next = DATA;
                end
            end

            DATA: begin
                w_valid     = tlp_bus.tlp_valid_i;
                w_data[7:0] = w_byte;
                if (w_xfer) begin
                    w_cnt_next = w_cnt_wrap;
                    if (r_byte_idx == w_last_idx) begin
                        // Word fully serialized: release it to the source.
                        w_ready           = 1'b1;
                        w_byte_idx_next   = 2'd0;
                        w_first_word_next = 1'b0;
                        w_frame_err_next  = tlp_bus.tlp_sop_i & ~r_first_word;
                        if (tlp_bus.tlp_eop_i) begin
                            w_state_next = END;
                        end
                    end else begin
                        w_byte_idx_next = r_byte_idx + 2'd1;
                    end
                end
            end

            END, PAD: begin
                w_valid     = 1'b1;
                w_is_k      = 1'b1;
                w_data[7:0] = (r_state == END) ? K_END : K_PAD;
                if (w_xfer) begin
                    w_cnt_next = w_cnt_wrap;
                    if (w_cnt_wrap == '0) begin
                        // Frame aligned. Chain straight into the next packet
                        // when its sop word is already waiting.
                        w_byte_idx_next = 2'd0;
                        if (tlp_bus.tlp_valid_i && tlp_bus.tlp_sop_i) begin
                            w_state_next      = STP;
                            w_lanes_next      = w_lanes_now;
                            w_first_word_next = 1'b1;
                        end else begin
                            w_state_next = IDLE;
                        end
                    end else begin
                        w_state_next = PAD;
                    end
                end
            end

            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // State, counters and the registered error pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_lanes      <= LANE_W'(1);
            r_byte_idx   <= 2'd0;
            r_first_word <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_cnt        <= w_cnt_next;
            r_lanes      <= w_lanes_next;
            r_byte_idx   <= w_byte_idx_next;
            r_first_word <= w_first_word_next;
            r_frame_err  <= w_frame_err_next;
        end
    end

    // The IDLE discard path is input-driven, so gate it with reset.
    assign tlp_bus.tlp_ready_o    = w_ready & rst_ni;
    assign tlp_bus.framed_valid_o = w_valid;
    assign tlp_bus.framed_is_k_o  = w_is_k;
    assign tlp_bus.framed_data_o  = w_data;
    assign frame_err_o            = r_frame_err;

endmodule
